// File: rtl/register_file_param.sv
// register_file_param: two-read/one-write register file with optional write forwarding
// and a three-state FSM that sweeps every register to zero on request.
module register_file_param #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH),
  parameter bit BYPASS = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  input  logic             clr_start,
  output logic             busy,
  output logic             clr_done
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_en, last;
  assign busy     = state_q != IDLE;
  assign clr_done = state_q == DONE;
  assign wr_en    = LD_REG && !busy;
  assign last     = idx_q == AW'(DEPTH - 1);
  // idx holds at DEPTH-1 on the final sweep edge so it never starts a second pass
  always_comb begin
    state_d = (state_q == IDLE)  ? (clr_start ? CLEAR : IDLE) :
              (state_q == CLEAR) ? (last ? DONE : CLEAR) : IDLE;
    idx_d   = (state_q == IDLE) ? '0 :
              (state_q == CLEAR && !last) ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (wr_en) regs_q[DR] <= data_in;
      if (state_q == CLEAR) regs_q[idx_q] <= '0;
    end
  end
  assign SR1_OUT = (BYPASS && wr_en && SR1 == DR) ? data_in : regs_q[SR1];
  assign SR2_OUT = (BYPASS && wr_en && SR2 == DR) ? data_in : regs_q[SR2];
endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, register data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of registers, a power of two and at least 2.
REQ-003 The block SHALL have parameter AW, default $clog2(DEPTH), address width.
REQ-004 The block SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding and 0 disables it.
REQ-005 The block SHALL have port Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port LD_REG  input  1  write enable.
REQ-008 The block SHALL have port DR  input  AW  write address.
REQ-009 The block SHALL have port data_in  input  WIDTH  write data.
REQ-010 The block SHALL have ports SR1, SR2  input  AW  read addresses for ports 1 and 2.
REQ-011 The block SHALL have ports SR1_OUT, SR2_OUT  output  WIDTH  read data for ports 1 and 2.
REQ-012 The block SHALL have port clr_start  input  1  request to sweep-clear all registers.
REQ-013 The block SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-014 The block SHALL have port clr_done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-015 The block SHALL hold DEPTH registers of WIDTH bits each.
REQ-016 When LD_REG=1 and busy=0, the block SHALL write data_in to register DR at the rising edge.
REQ-017 When busy=1, the block SHALL ignore LD_REG and perform no write.
REQ-018 Reads SHALL be combinational: SRx_OUT = reg[SRx], with zero-cycle latency.
REQ-019 When BYPASS=1, LD_REG=1, busy=0 and SRx==DR, SRx_OUT SHALL equal data_in (write-first forwarding); this SHALL apply to each port independently.
REQ-020 When BYPASS=0, SRx_OUT SHALL always show the stored value; a write SHALL become visible in the cycle after its edge.
REQ-021 The FSM SHALL have exactly three states: IDLE, CLEAR and DONE.
REQ-022 In IDLE with clr_start=1, the FSM SHALL go to CLEAR at the next edge and set index counter idx to 0.
REQ-023 In CLEAR, each edge SHALL write 0 to reg[idx] and increment idx; the edge that clears reg[DEPTH-1] SHALL move the FSM to DONE, so CLEAR lasts exactly DEPTH cycles.
REQ-024 In DONE, the FSM SHALL return to IDLE at the next edge.
REQ-025 busy SHALL be 1 in CLEAR and DONE and 0 in IDLE.
REQ-026 clr_done SHALL be 1 only in DONE.
REQ-027 From the clr_start edge to return to IDLE, the sweep SHALL take DEPTH+1 cycles with busy=1.
REQ-028 clr_start SHALL be ignored while busy=1; it SHALL not be queued or restart the sweep.
REQ-029 When clr_start=1 and LD_REG=1 in the same IDLE cycle, the write SHALL occur at that edge and the sweep SHALL begin, so the written register is later cleared.
REQ-030 Reads during CLEAR SHALL return current array contents: registers already swept read 0 and the rest read their old values.
REQ-031 idx SHALL be AW bits wide and SHALL not wrap into a second pass.

Reset
REQ-032 Reset=1 SHALL asynchronously force all registers to 0, the FSM to IDLE, idx to 0, busy to 0 and clr_done to 0, regardless of Clk.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE and all registers SHALL be 0.
REQ-034 After Reset deasserts, the first rising edge SHALL accept a write or clr_start normally.

Verification
REQ-035 Bench SHALL cover: Reset pulse -> every SRx_OUT=0, busy=0, clr_done=0.
REQ-036 Bench SHALL cover: write R3=0x1234 and R5=0xBEEF, then SR1=3, SR2=5 -> SR1_OUT=0x1234, SR2_OUT=0xBEEF.
REQ-037 Bench SHALL cover: BYPASS=1 with LD_REG=1, DR=2, data_in=0xA5A5, SR1=2 in the same cycle -> SR1_OUT=0xA5A5 before the edge; with BYPASS=0 -> old value before the edge and 0xA5A5 after.
REQ-038 Bench SHALL cover: fill R0-R7 with nonzero values, pulse clr_start -> busy=1 for 9 cycles, clr_done=1 in the 9th cycle only, all registers 0 afterwards, and a write R1=0x0F0F attempted in cycle 4 is not stored.
REQ-039 Bench SHALL cover: clr_start together with a write of R7=0x7777 -> R7 reads 0x7777 during the first DEPTH-1 sweep cycles and 0 after DONE, and a second clr_start mid-sweep leaves the timing unchanged.
REQ-040 Bench SHALL cover: assert Reset during sweep cycle 3 with no Clk edge -> busy=0 immediately, all registers 0, and a write R4=0x4444 right after release succeeds.
